mdu_controller: RTL

//  Sequences an iterative RV32M multiply/divide unit that sits beside the ALU in the EX stage.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_iter_core.sv | 36 +++
 rtl/mdu_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational step of shift-add multiply or restoring divide on {acc,quot}.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + (quot_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, quot_i[XLEN-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = '0;
    quot_o  = '0;
    if (!div_i) begin
      // Multiplier bits retire from quot's LSB while product bits enter at its MSB.
      acc_o  = sum[XLEN:1];
      quot_o = {sum[0], quot_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o  = shifted[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_controller.sv
// Sequencer for the iterative RV32M unit: accepts an op from EX, stalls the
// pipeline for XLEN iterations (or one cycle for special cases), strobes the result.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  mdu_state_t      state_q;
  logic [CNT_W-1:0] count_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_q, quot_q, opnd_q;
  logic [XLEN-1:0] acc_d, quot_d;

  logic            accept, is_div, sa, sb, neg_in, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, acc_spec, quot_spec;

  always_comb begin
    accept   = (state_q == IDLE) && start_i && !flush_i;
    is_div   = funct3_i[2];
    sa       = op_a_i[XLEN-1] && (funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sb       = op_b_i[XLEN-1] && (funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
    mag_a    = neg_if(op_a_i, sa);
    mag_b    = neg_if(op_b_i, sb);
    // Remainder follows the dividend's sign; everything else follows sa^sb.
    neg_in   = (is_div && funct3_i[1]) ? sa : (sa ^ sb);
    div_zero = is_div && (op_b_i == '0);
    div_ovf  = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
               (op_a_i == INT_MIN) && (op_b_i == '1);
    special  = div_zero || div_ovf;
    // Special results are parked where the final mux looks: quot for DIV*, acc for REM*.
    acc_spec  = div_zero ? op_a_i : '0;
    quot_spec = div_zero ? '1 : op_a_i;
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .div_i  (f3_q[2]),
    .acc_i  (acc_q),
    .quot_i (quot_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d),
    .quot_o (quot_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      quot_q  <= '0;
      opnd_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q    <= funct3_i;
            count_q <= '0;
            if (special) begin
              neg_q   <= 1'b0;
              acc_q   <= acc_spec;
              quot_q  <= quot_spec;
              opnd_q  <= '0;
              state_q <= DONE;
            end else begin
              neg_q   <= neg_in;
              acc_q   <= '0;
              quot_q  <= is_div ? mag_a : mag_b;
              opnd_q  <= is_div ? mag_b : mag_a;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q   <= acc_d;
            quot_q  <= quot_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_CNT) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   res_sel;

  always_comb begin
    prod_s  = neg_q ? -{acc_q, quot_q} : {acc_q, quot_q};
    res_sel = '0;
    unique case (f3_q)
      F3_MUL:                       res_sel = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              res_sel = neg_if(quot_q, neg_q);
      default:                      res_sel = neg_if(acc_q, neg_q);
    endcase
  end

  // Flush kills the stall and the result strobe in the same cycle it arrives.
  assign stall_o  = accept || ((state_q == BUSY) && !flush_i);
  assign done_o   = (state_q == DONE) && !flush_i;
  assign result_o = done_o ? res_sel : '0;
  assign busy_o   = (state_q != IDLE);

endmodule
